// File: rtl/ttc_ovs_frame_decoder.sv
// rtl/ttc_ovs_frame_decoder.sv - oversampled TTC phase picker, bit recovery and frame aligner
// Samples each bit opposite the observed edge, then locks WIDTH-bit frames on a SYNC header.
module ttc_ovs_frame_decoder #(
  parameter int                    OVS          = 4,
  parameter int                    WIDTH        = 16,
  parameter int                    SYNC_WIDTH   = 4,
  parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 4'hA,
  parameter int                    LOCK_CNT     = 4,
  parameter int                    UNLOCK_CNT   = 2,
  parameter int                    PHASE_HYST   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [OVS-1:0]           samples,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic                     locked,
  output logic [$clog2(OVS)-1:0]   phase,
  output logic                     err
);

  localparam int              PW       = $clog2(OVS);
  localparam int              BW       = $clog2(WIDTH);
  localparam logic [PW-1:0]   HALF     = PW'(OVS / 2);
  localparam logic [BW-1:0]   BLAST    = BW'(WIDTH - 1);
  localparam logic [8:0]      HYST_LIM = 9'(PHASE_HYST);
  localparam logic [3:0]      LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0]      UNLOCK_N = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

  state_t           state_q;
  logic             prev_q;
  logic             bit_q;
  logic [WIDTH-1:0] sr_q;
  logic [BW-1:0]    bcnt_q;
  logic [PW-1:0]    phase_q, phase_d;
  logic [7:0]       hyst_q, hyst_d;
  logic             moved_q, moved_d;
  logic [3:0]       mcnt_q;
  logic [3:0]       miss_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             locked_q;
  logic             err_q;

  logic [OVS:0]     seq;
  logic [OVS-1:0]   edges;
  logic [PW-1:0]    edge_pos;
  logic [PW-1:0]    cand;
  logic             single;
  logic             wrap;
  logic             hdr_ok;

  // A lone transition marks the bit boundary; its half-period opposite is the safest sample.
  always_comb begin
    seq      = {prev_q, samples};
    edges    = seq[OVS:1] ^ seq[OVS-1:0];
    edge_pos = '0;
    for (int p = 0; p < OVS; p++) begin
      if (edges[p]) edge_pos = PW'(p);
    end
    single   = (edges != '0) && ((edges & (edges - OVS'(1))) == '0);
    cand     = edge_pos + HALF;
    phase_d  = phase_q;
    hyst_d   = hyst_q;
    moved_d  = 1'b0;
    if (single) begin
      if (cand == phase_q) begin
        hyst_d = '0;
      end else if ({1'b0, hyst_q} + 9'd1 >= HYST_LIM) begin
        phase_d = cand;
        hyst_d  = '0;
        moved_d = 1'b1;
      end else begin
        hyst_d = hyst_q + 8'd1;
      end
    end
  end

  assign wrap   = (bcnt_q == BLAST);
  assign hdr_ok = (sr_q[WIDTH-1 -: SYNC_WIDTH] == SYNC_PATTERN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      prev_q   <= 1'b0;
      bit_q    <= 1'b0;
      sr_q     <= '0;
      bcnt_q   <= '0;
      phase_q  <= HALF;
      hyst_q   <= '0;
      moved_q  <= 1'b0;
      mcnt_q   <= '0;
      miss_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q  <= samples[0];
      bit_q   <= samples[phase_q];
      phase_q <= phase_d;
      hyst_q  <= hyst_d;
      moved_q <= moved_d;
      sr_q    <= {sr_q[WIDTH-2:0], bit_q};
      bcnt_q  <= wrap ? '0 : bcnt_q + BW'(1);
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          if (hdr_ok) begin
            state_q <= ST_VERIFY;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
          end
        end
        ST_VERIFY: begin
          // A phase move restarts verification but keeps the frame offset.
          if (moved_q) begin
            mcnt_q <= '0;
          end else if (wrap) begin
            if (!hdr_ok) begin
              state_q <= ST_HUNT;
            end else if (mcnt_q + 4'd1 == LOCK_N) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              data_q   <= sr_q;
              valid_q  <= 1'b1;
              miss_q   <= '0;
            end else begin
              mcnt_q <= mcnt_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (moved_q) begin
            state_q  <= ST_VERIFY;
            mcnt_q   <= '0;
            locked_q <= 1'b0;
          end else if (wrap) begin
            if (hdr_ok) begin
              data_q  <= sr_q;
              valid_q <= 1'b1;
              miss_q  <= '0;
            end else begin
              err_q <= 1'b1;
              if (miss_q + 4'd1 == UNLOCK_N) begin
                state_q  <= ST_HUNT;
                locked_q <= 1'b0;
              end else begin
                miss_q <= miss_q + 4'd1;
              end
            end
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign locked = locked_q;
  assign phase  = phase_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ttc_ovs_frame_decoder.sv
// tb/tb_ttc_ovs_frame_decoder.sv - frame-table bench for ttc_ovs_frame_decoder
// Each table row is one 16-bit frame with its stimulus shape and the outputs expected in its slot.
module tb_ttc_ovs_frame_decoder;

  localparam int NF = 36;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  samples = 4'h0;
  logic [15:0] data;
  logic        valid;
  logic        locked;
  logic [1:0]  phase;
  logic        err;

  always #5 clk = ~clk;

  ttc_ovs_frame_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .samples (samples),
    .data    (data),
    .valid   (valid),
    .locked  (locked),
    .phase   (phase),
    .err     (err)
  );

  // p1: position-1 edge clocks allowed in this frame (255 = whole frame)
  typedef struct {
    logic [15:0] word;
    int          p1;
    bit          glitch;
    int          move_j;
    int          rst_j;
    bit          ev;
    bit          ee;
    bit          el;
  } frame_t;

  frame_t      tbl [NF];
  logic        bits [NF*16+32];
  int          nf = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_data;
  logic [1:0]  exp_phase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] w, input int p1, input bit g, input int mv,
                     input int rj, input bit ev, input bit ee, input bit el);
    tbl[nf] = '{w, p1, g, mv, rj, ev, ee, el};
    nf++;
  endtask

  function automatic logic [3:0] mkvec(input int k, input bit p1, input bit g);
    logic b, n;
    b = bits[k];
    n = bits[k+1];
    if (p1) mkvec = {b, b, n, n};
    else    mkvec = {g ? ~b : b, b, b, n};
  endfunction

  task automatic check_slot(input int f);
    if (tbl[f].ev) exp_data = tbl[f].word;
    chk($sformatf("f%0d valid", f),  32'(valid),  32'(tbl[f].ev));
    chk($sformatf("f%0d err", f),    32'(err),    32'(tbl[f].ee));
    chk($sformatf("f%0d locked", f), 32'(locked), 32'(tbl[f].el));
    chk($sformatf("f%0d data", f),   32'(data),   32'(exp_data));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " data"},   32'(data),   32'h0);
    chk({tag, " valid"},  32'(valid),  32'h0);
    chk({tag, " locked"}, 32'(locked), 32'h0);
    chk({tag, " err"},    32'(err),    32'h0);
    chk({tag, " phase"},  32'(phase),  32'h2);
  endtask

  initial begin
    //   word     p1  gl  mv  rj  v  e  l
    add(16'hA123,   0, 0, -1, -1, 0, 0, 0);  // HUNT match
    add(16'hA456,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA789,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA123,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA456,   0, 0, -1, -1, 1, 0, 1);  // 4th verified frame locks
    add(16'hA789,   0, 0, -1, -1, 1, 0, 1);
    add(16'hA123,   0, 0, -1, -1, 1, 0, 1);
    add(16'hA456,   0, 0, -1, -1, 1, 0, 1);
    add(16'hA789,   0, 1, -1, -1, 1, 0, 1);  // double-transition vectors
    add(16'hA123,   0, 1, -1, -1, 1, 0, 1);
    add(16'hB000,   0, 0, -1, -1, 0, 1, 1);  // single bad header
    add(16'hA789,   0, 0, -1, -1, 1, 0, 1);
    add(16'hB000,   0, 0, -1, -1, 0, 1, 1);
    add(16'hB000,   0, 0, -1, -1, 0, 1, 0);  // second miss unlocks
    add(16'hA123,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA456,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA789,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA123,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA456,   0, 0, -1, -1, 1, 0, 1);
    add(16'hA789,   0, 0, -1, -1, 1, 0, 1);
    add(16'hA123,   7, 0, -1, -1, 1, 0, 1);  // 7 shifted edges then a centred one
    add(16'hA456, 255, 0, 10, -1, 0, 0, 0);  // 8th shifted edge at j=10 moves phase
    add(16'hA789, 255, 0, -1, -1, 0, 0, 0);
    add(16'hA123, 255, 0, -1, -1, 0, 0, 0);
    add(16'hA456, 255, 0, -1, -1, 1, 0, 1);
    add(16'hA789, 255, 0, -1, -1, 1, 0, 1);
    add(16'hA000,   0, 0, -1,  5, 0, 0, 0);  // reset mid-frame
    add(16'h0A00,   0, 0, -1, -1, 0, 0, 0);  // false header
    add(16'hA123,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA456,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA789,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA123,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA456,   0, 0, -1, -1, 0, 0, 0);
    add(16'hA789,   0, 0, -1, -1, 1, 0, 1);
    add(16'hA123,   0, 0, -1, -1, 1, 0, 1);
    add(16'hA456,   0, 0, -1, -1, 1, 0, 1);

    for (int k = 0; k < NF*16+32; k++) bits[k] = 1'b0;
    for (int i = 0; i < nf; i++)
      for (int j = 0; j < 16; j++)
        bits[16*i+j] = tbl[i].word[15-j];

    rst_n   = 1'b0;
    samples = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n     = 1'b1;
    exp_data  = 16'h0;
    exp_phase = 2'd2;

    for (int i = 0; i < nf; i++) begin
      int p1cnt;
      p1cnt = 0;
      for (int j = 0; j < 16; j++) begin
        int k;
        bit use1;
        k    = 16*i + j;
        use1 = (tbl[i].p1 > p1cnt);
        samples = mkvec(k, use1, tbl[i].glitch && (j % 3 == 0));
        if (use1 && (bits[k] != bits[k+1])) p1cnt++;
        rst_n = (j == tbl[i].rst_j) ? 1'b0 : 1'b1;
        @(posedge clk);
        #1;
        if (j == tbl[i].rst_j) begin
          exp_data  = 16'h0;
          exp_phase = 2'd2;
          check_reset("midreset");
        end
        if (j == tbl[i].move_j) exp_phase = 2'd3;
        chk($sformatf("f%0d j%0d phase", i, j), 32'(phase), 32'(exp_phase));
        if (tbl[i].move_j >= 0)
          chk($sformatf("f%0d j%0d relock drop", i, j), 32'(locked), 32'(j <= tbl[i].move_j));
        if (j == 1 && i > 0)
          check_slot(i - 1);
        else
          chk($sformatf("f%0d j%0d quiet", i, j), 32'({valid, err}), 32'h0);
      end
    end
    rst_n = 1'b1;

    for (int j = 0; j < 2; j++) begin
      samples = mkvec(16*nf + j, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      if (j == 1) check_slot(nf - 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
